// File: rtl/video_tg_cfg_pkg.sv
// Shared state encoding and AXI constants for the video_tg configuration sequencer.
package video_tg_cfg_pkg;

   typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP, DONE} state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam int         REG_STRIDE      = 4;

endpackage

// File: rtl/video_tg_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS words of cfg_data into the video_tg register bank on start.
// Optional macro VIDEO_TG_CFG_READBACK_EN adds a read-back pass that verifies every register after the writes.
module video_tg_cfg_sequencer
   import video_tg_cfg_pkg::*;
#(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter int                            NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
)(
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   input  logic                                   start,
   input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   error,
   output logic [3:0]                             err_idx,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
   output logic [2:0]                             M_AXI_AWPROT,
   output logic                                   M_AXI_AWVALID,
   input  logic                                   M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
   output logic                                   M_AXI_WVALID,
   input  logic                                   M_AXI_WREADY,
   input  logic [1:0]                             M_AXI_BRESP,
   input  logic                                   M_AXI_BVALID,
   output logic                                   M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
   output logic [2:0]                             M_AXI_ARPROT,
   output logic                                   M_AXI_ARVALID,
   input  logic                                   M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
   input  logic [1:0]                             M_AXI_RRESP,
   input  logic                                   M_AXI_RVALID,
   output logic                                   M_AXI_RREADY
);

   localparam int         DW       = C_M_AXI_DATA_WIDTH;
   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   state_t                         state;
   logic [3:0]                     idx;
   logic                           issued;
   logic                           aw_done;
   logic                           w_done;
   logic [NUM_REGS*DW-1:0]         shadow;
   logic                           aw_hs;
   logic                           w_hs;
   logic [C_M_AXI_ADDR_WIDTH-1:0]  cur_addr;
   logic [DW-1:0]                  cur_data;

   assign aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_hs     = M_AXI_WVALID & M_AXI_WREADY;
   assign cur_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(int'(idx) * REG_STRIDE);
   assign cur_data = shadow[int'(idx)*DW +: DW];

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_ARPROT = 3'b000;

`ifdef VIDEO_TG_CFG_READBACK_EN
   logic ar_hs;
   assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
`else
   logic unused_rd;
   assign M_AXI_ARVALID = 1'b0;
   assign M_AXI_RREADY  = 1'b1;
   assign M_AXI_ARADDR  = BASE_ADDR;
   assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

   // One register per pass: WR issues AW+W together (issued=0 is the issue cycle),
   // each VALID retires on its own handshake, then WRESP waits for B.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state         <= IDLE;
         idx           <= '0;
         issued        <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         shadow        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_idx       <= '0;
         M_AXI_AWADDR  <= BASE_ADDR;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
`ifdef VIDEO_TG_CFG_READBACK_EN
         M_AXI_ARADDR  <= BASE_ADDR;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shadow <= cfg_data;
                  idx    <= '0;
                  error  <= 1'b0;
                  busy   <= 1'b1;
                  issued <= 1'b0;
                  state  <= WR;
               end
            end
            WR: begin
               if (!issued) begin
                  M_AXI_AWADDR  <= cur_addr;
                  M_AXI_WDATA   <= cur_data;
                  M_AXI_AWVALID <= 1'b1;
                  M_AXI_WVALID  <= 1'b1;
                  issued        <= 1'b1;
                  aw_done       <= 1'b0;
                  w_done        <= 1'b0;
               end else begin
                  if (aw_hs) begin
                     M_AXI_AWVALID <= 1'b0;
                     aw_done       <= 1'b1;
                  end
                  if (w_hs) begin
                     M_AXI_WVALID <= 1'b0;
                     w_done       <= 1'b1;
                  end
                  if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                     M_AXI_BREADY <= 1'b1;
                     state        <= WRESP;
                  end
               end
            end
            WRESP: begin
               if (M_AXI_BVALID) begin
                  M_AXI_BREADY <= 1'b0;
                  issued       <= 1'b0;
                  if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                     error   <= 1'b1;
                     err_idx <= idx;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end else if (idx == LAST_IDX) begin
`ifdef VIDEO_TG_CFG_READBACK_EN
                     idx   <= '0;
                     state <= RD;
`else
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
`endif
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= WR;
                  end
               end
            end
`ifdef VIDEO_TG_CFG_READBACK_EN
            RD: begin
               if (!issued) begin
                  M_AXI_ARADDR  <= cur_addr;
                  M_AXI_ARVALID <= 1'b1;
                  issued        <= 1'b1;
               end else if (ar_hs) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state         <= RRESP;
               end
            end
            // A bad response or a word that differs from what was written ends the sequence.
            RRESP: begin
               if (M_AXI_RVALID) begin
                  M_AXI_RREADY <= 1'b0;
                  issued       <= 1'b0;
                  if (M_AXI_RRESP != AXI_RESP_OKAY || M_AXI_RDATA != cur_data) begin
                     error   <= 1'b1;
                     err_idx <= idx;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end else if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= RD;
                  end
               end
            end
`endif
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_tg_cfg_sequencer.sv
// Self-checking bench for video_tg_cfg_sequencer with a delay-configurable AXI4-Lite slave and write/read scoreboards.
// Honours VIDEO_TG_CFG_READBACK_EN to expect and exercise the read-back pass.
module tb_video_tg_cfg_sequencer;
   import video_tg_cfg_pkg::*;

   localparam int NREG = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [127:0] cfg;
      int           aw_d;
      int           w_d;
      int           b_d;
      int           slv_reg;
      int           rd_bad;
      logic         exp_err;
      logic [3:0]   exp_idx;
   } vec_t;

   logic         ACLK = 1'b0;
   logic         ARESET;
   logic         start;
   logic [127:0] cfg_data;
   logic         busy, done, error;
   logic [3:0]   err_idx;
   logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;
   logic [2:0]   AWPROT, ARPROT;
   logic [3:0]   WSTRB;
   logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic         ARVALID, ARREADY, RVALID, RREADY;
   logic [1:0]   BRESP, RRESP;

   int n_vec = 0;
   int n_err = 0;

   int aw_delay, w_delay, b_delay, slv_reg, rd_bad;
   int aw_wait, w_wait, b_wait, ar_wait;
   int b_pending, resp_idx, done_cnt;
   logic b_hs_next, r_hs_next, aw_hs_flag, w_hs_flag, ar_hs_flag;
   logic [31:0] aw_hold, w_hold, ar_hold, sl_a, sl_d;
   logic [31:0] aw_obs[$];
   logic [31:0] w_obs[$];
   logic [31:0] rd_pend[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] mem[16];
   wr_t         exp_q[$];
   wr_t         sl_e;
   vec_t        vecs[$];

   always #5 ACLK = ~ACLK;

   video_tg_cfg_sequencer #(
      .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NREG), .BASE_ADDR(32'h0)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error), .err_idx(err_idx),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave model: decides READY/response for the next rising edge on each falling edge,
   // so a handshake is known one half-cycle before it happens.
   always @(negedge ACLK) begin
      if (ARESET) begin
         AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = AXI_RESP_OKAY;
         ARREADY = 1'b0; RVALID = 1'b0; RRESP = AXI_RESP_OKAY; RDATA = '0;
         aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; b_pending = 0;
         b_hs_next = 1'b0; r_hs_next = 1'b0;
         aw_hs_flag = 1'b0; w_hs_flag = 1'b0; ar_hs_flag = 1'b0;
         aw_obs.delete(); w_obs.delete(); rd_pend.delete();
      end else begin
         if (done) done_cnt++;

         if (BVALID) begin
            if (b_hs_next) begin BVALID = 1'b0; b_hs_next = 1'b0; end
            else if (BREADY) b_hs_next = 1'b1;
         end else if (b_pending > 0) begin
            if (b_wait >= b_delay) begin
               BVALID = 1'b1;
               BRESP  = (resp_idx == slv_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               resp_idx++; b_pending--; b_wait = 0;
               b_hs_next = BREADY;
            end else b_wait++;
         end

         if (aw_hs_flag) begin checkOutput("awvalid_drop", 32'(AWVALID), 0); aw_hs_flag = 1'b0; end
         if (AWVALID) begin
            if (aw_wait == 0) aw_hold = AWADDR;
            else checkOutput("awaddr_stable", AWADDR, aw_hold);
            if (aw_wait >= aw_delay) begin
               AWREADY = 1'b1; aw_obs.push_back(AWADDR); aw_hs_flag = 1'b1; aw_wait = 0;
            end else begin AWREADY = 1'b0; aw_wait++; end
         end else begin AWREADY = 1'b0; aw_wait = 0; end

         if (w_hs_flag) begin checkOutput("wvalid_drop", 32'(WVALID), 0); w_hs_flag = 1'b0; end
         if (WVALID) begin
            if (w_wait == 0) w_hold = WDATA;
            else checkOutput("wdata_stable", WDATA, w_hold);
            if (w_wait >= w_delay) begin
               checkOutput("wstrb", 32'(WSTRB), 32'hF);
               WREADY = 1'b1; w_obs.push_back(WDATA); w_hs_flag = 1'b1; w_wait = 0;
            end else begin WREADY = 1'b0; w_wait++; end
         end else begin WREADY = 1'b0; w_wait = 0; end

         if (aw_obs.size() > 0 && w_obs.size() > 0) begin
            sl_a = aw_obs.pop_front();
            sl_d = w_obs.pop_front();
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("[TB] FAIL extra_write: got addr %h data %h, expected no write", sl_a, sl_d);
            end else begin
               sl_e = exp_q.pop_front();
               checkOutput("wr_addr", sl_a, sl_e.addr);
               checkOutput("wr_data", sl_d, sl_e.data);
            end
            mem[sl_a[5:2]] = sl_d;
            b_pending++;
         end

         if (RVALID) begin
            if (r_hs_next) begin RVALID = 1'b0; r_hs_next = 1'b0; end
            else if (RREADY) r_hs_next = 1'b1;
         end else if (rd_pend.size() > 0) begin
            sl_a   = rd_pend.pop_front();
            RDATA  = (int'(sl_a[5:2]) == rd_bad) ? 32'h0000_DEAD : mem[sl_a[5:2]];
            RRESP  = AXI_RESP_OKAY;
            RVALID = 1'b1;
            r_hs_next = RREADY;
         end

         if (ar_hs_flag) begin checkOutput("arvalid_drop", 32'(ARVALID), 0); ar_hs_flag = 1'b0; end
         if (ARVALID) begin
            if (ar_wait == 0) ar_hold = ARADDR;
            else checkOutput("araddr_stable", ARADDR, ar_hold);
            if (ar_wait >= aw_delay) begin
               ARREADY = 1'b1; ar_hs_flag = 1'b1; ar_wait = 0;
               rd_pend.push_back(ARADDR);
               if (exp_rd_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("[TB] FAIL extra_read: got addr %h, expected no read", ARADDR);
               end else checkOutput("rd_addr", ARADDR, exp_rd_q.pop_front());
            end else begin ARREADY = 1'b0; ar_wait++; end
         end else begin ARREADY = 1'b0; ar_wait = 0; end
      end
   end

   task automatic pushExpect(input logic [127:0] cfg, input int slv, input int rdb);
      int nwr = (slv >= 0) ? slv + 1 : NREG;
      for (int i = 0; i < nwr; i++) exp_q.push_back('{addr: 32'(4*i), data: cfg[32*i +: 32]});
`ifdef VIDEO_TG_CFG_READBACK_EN
      if (slv < 0)
         for (int i = 0; i < NREG; i++)
            if (rdb < 0 || i <= rdb) exp_rd_q.push_back(32'(4*i));
`else
      if (rdb >= NREG) $display("[TB] note: read-back index %0d ignored", rdb);
`endif
   endtask

   task automatic waitDone(input string name);
      int k = 0;
      while (!done && k < 600) begin @(negedge ACLK); k++; end
      if (!done) begin
         n_vec++; n_err++;
         $display("[TB] FAIL %s: got no done pulse, expected one within 600 cycles", name);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      aw_delay = v.aw_d; w_delay = v.w_d; b_delay = v.b_d;
      slv_reg = v.slv_reg; rd_bad = v.rd_bad; resp_idx = 0;
      pushExpect(v.cfg, v.slv_reg, v.rd_bad);
      cfg_data = v.cfg;
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 1);
      checkOutput("awvalid_lat1", 32'(AWVALID), 0);
      @(negedge ACLK);
      checkOutput("awvalid_lat2", 32'(AWVALID), 1);
      waitDone("done_timeout");
      checkOutput("error_at_done", 32'(error), 32'(v.exp_err));
      checkOutput("busy_at_done", 32'(busy), 0);
      if (v.exp_err) checkOutput("err_idx", 32'(err_idx), 32'(v.exp_idx));
      @(negedge ACLK);
      checkOutput("done_single", 32'(done), 0);
      checkOutput("error_held", 32'(error), 32'(v.exp_err));
      checkOutput("writes_left", 32'(exp_q.size()), 0);
      checkOutput("reads_left", 32'(exp_rd_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ARESET = 1'b1; start = 1'b0; cfg_data = '0;
      aw_delay = 0; w_delay = 0; b_delay = 0; slv_reg = -1; rd_bad = -1;
      resp_idx = 0; done_cnt = 0;

      vecs.push_back('{cfg: {32'd4, 32'd3, 32'd2, 32'd1}, aw_d: 0, w_d: 0, b_d: 0,
                       slv_reg: -1, rd_bad: -1, exp_err: 1'b0, exp_idx: 4'd0});
      vecs.push_back('{cfg: {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, aw_d: 3, w_d: 7, b_d: 5,
                       slv_reg: -1, rd_bad: -1, exp_err: 1'b0, exp_idx: 4'd0});
      vecs.push_back('{cfg: {32'd4, 32'd3, 32'd2, 32'd1}, aw_d: 0, w_d: 0, b_d: 0,
                       slv_reg: 2, rd_bad: -1, exp_err: 1'b1, exp_idx: 4'd2});
      vecs.push_back('{cfg: {32'hCAFE_F00D, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF}, aw_d: 1, w_d: 0, b_d: 2,
                       slv_reg: 0, rd_bad: -1, exp_err: 1'b1, exp_idx: 4'd0});
      vecs.push_back('{cfg: {32'h0, 32'hA5A5_5A5A, 32'h0000_0001, 32'h7FFF_FFFF}, aw_d: 0, w_d: 2, b_d: 0,
                       slv_reg: 3, rd_bad: -1, exp_err: 1'b1, exp_idx: 4'd3});
      vecs.push_back('{cfg: {32'h0BAD_F00D, 32'h5555_AAAA, 32'h0F0F_0F0F, 32'h1357_9BDF}, aw_d: 7, w_d: 3, b_d: 1,
                       slv_reg: -1, rd_bad: -1, exp_err: 1'b0, exp_idx: 4'd0});
`ifdef VIDEO_TG_CFG_READBACK_EN
      vecs.push_back('{cfg: {32'd4, 32'd3, 32'd2, 32'd1}, aw_d: 0, w_d: 0, b_d: 0,
                       slv_reg: -1, rd_bad: 1, exp_err: 1'b1, exp_idx: 4'd1});
`endif

      repeat (2) @(negedge ACLK);
      checkOutput("rst_awvalid", 32'(AWVALID), 0);
      checkOutput("rst_wvalid", 32'(WVALID), 0);
      checkOutput("rst_bready", 32'(BREADY), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_error", 32'(error), 0);
      checkOutput("rst_err_idx", 32'(err_idx), 0);
      checkOutput("rst_awaddr", AWADDR, 32'h0);
      checkOutput("rst_wdata", WDATA, 32'h0);
      checkOutput("rst_arvalid", 32'(ARVALID), 0);
      checkOutput("rst_araddr", ARADDR, 32'h0);
`ifdef VIDEO_TG_CFG_READBACK_EN
      checkOutput("rst_rready", 32'(RREADY), 0);
`else
      checkOutput("tie_rready", 32'(RREADY), 1);
`endif
      ARESET = 1'b0;
      @(negedge ACLK);

      foreach (vecs[v]) applyStimulus(vecs[v]);

      // Second start and cfg_data change while busy must not disturb the latched sequence.
      aw_delay = 2; w_delay = 2; b_delay = 2; slv_reg = -1; rd_bad = -1; resp_idx = 0; done_cnt = 0;
      pushExpect({32'h40, 32'h30, 32'h20, 32'h10}, -1, -1);
      cfg_data = {32'h40, 32'h30, 32'h20, 32'h10};
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      repeat (4) @(negedge ACLK);
      cfg_data = {4{32'hFFFF_FFFF}};
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      waitDone("ign_done_timeout");
      repeat (30) @(negedge ACLK);
      checkOutput("ign_done_count", 32'(done_cnt), 1);
      checkOutput("ign_writes_left", 32'(exp_q.size()), 0);
      checkOutput("ign_error", 32'(error), 0);

      // Asynchronous reset while AW/W are pending, then a clean re-run from register 0.
      begin
         int k = 0;
         aw_delay = 6; w_delay = 6; b_delay = 0; resp_idx = 0;
         cfg_data = {32'h99, 32'h88, 32'h77, 32'h66};
         start = 1'b1;
         @(negedge ACLK);
         start = 1'b0;
         while (!AWVALID && k < 10) begin @(negedge ACLK); k++; end
         checkOutput("rst_mid_awvalid_seen", 32'(AWVALID), 1);
         #2 ARESET = 1'b1;
         #1;
         checkOutput("rst_mid_awvalid", 32'(AWVALID), 0);
         checkOutput("rst_mid_wvalid", 32'(WVALID), 0);
         checkOutput("rst_mid_busy", 32'(busy), 0);
         @(negedge ACLK);
         @(negedge ACLK);
         ARESET = 1'b0;
         exp_q.delete();
         exp_rd_q.delete();
         @(negedge ACLK);
         applyStimulus(vecs[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
